xoodyak_cmd_seq: RTL and testbench

Command sequencer and response collector that sits in front of `xoodyak_build` and acts as its driving end. It accepts Xoodyak operation commands (opmode + 352-bit data block) from a host over a valid/ready interface and queues them. It presents each command to the core for a fixed hold window, driving idle between commands. It captures every `textout_valid` pulse from the core into a response buffer that the host drains over a second valid/ready interface.

---
 rtl/xoodyak_cmd_seq.sv | 121 ++++++++++++
 tb/tb_xoodyak_cmd_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/xoodyak_cmd_seq.sv
// Command sequencer in front of xoodyak_build: queues host commands, holds each on the core
// inputs for HOLD_CYCLES, and buffers core outputs. Optional macro: XOOD_SEQ_STALL_EN.
module xoodyak_cmd_seq #(
    parameter int DEPTH       = 4,
    parameter int HOLD_CYCLES = 4
) (
    input  logic         eph1,
    input  logic         reset_n,
    input  logic         cmd_valid,
    output logic         cmd_ready,
    input  logic [4:0]   cmd_opmode,
    input  logic [351:0] cmd_data,
    output logic [4:0]   core_opmode,
    output logic [351:0] core_data,
    input  logic [191:0] core_textout,
    input  logic         core_textout_valid,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [191:0] rsp_text,
    output logic         busy,
    output logic         overrun
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam logic [AW:0]   FULL_COUNT = (AW+1)'(DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD  = HW'(HOLD_CYCLES - 1);

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_ISSUE = 1'b1;

    logic [4:0]    fifo_op   [DEPTH];
    logic [351:0]  fifo_data [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic [0:0]    state;
    logic [HW-1:0] hold_ctr;
    logic          push;
    logic          pop;
    logic          stall;
    logic          window_end;
    logic          drain;

    assign cmd_ready  = (count != FULL_COUNT);
    assign push       = cmd_valid & cmd_ready;
    assign drain      = rsp_valid & rsp_ready;
    assign busy       = (state == S_ISSUE) | (count != '0);
    assign window_end = (state == S_IDLE) | (hold_ctr == '0);
    assign pop        = window_end & (count != '0) & ~stall;

    // Holding back issue while the response buffer is full lets host back-pressure avoid overrun.
`ifdef XOOD_SEQ_STALL_EN
    assign stall = rsp_valid & ~rsp_ready;
`else
    assign stall = 1'b0;
`endif

    always_ff @(posedge eph1) begin
        if (push) begin
            fifo_op[wr_ptr]   <= cmd_opmode;
            fifo_data[wr_ptr] <= cmd_data;
        end
    end

    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push & ~pop)
                count <= count + 1'b1;
            else if (~push & pop)
                count <= count - 1'b1;
        end
    end

    // A pop always (re)starts a hold window, so back-to-back commands share no idle cycle.
    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            hold_ctr    <= '0;
            core_opmode <= '0;
            core_data   <= '0;
        end else if (pop) begin
            state       <= S_ISSUE;
            hold_ctr    <= HOLD_LOAD;
            core_opmode <= fifo_op[rd_ptr];
            core_data   <= fifo_data[rd_ptr];
        end else if (state == S_ISSUE) begin
            if (hold_ctr != '0) begin
                hold_ctr <= hold_ctr - 1'b1;
            end else begin
                state       <= S_IDLE;
                core_opmode <= '0;
                core_data   <= '0;
            end
        end
    end

    always_ff @(posedge eph1 or negedge reset_n) begin
        if (!reset_n) begin
            rsp_valid <= 1'b0;
            rsp_text  <= '0;
            overrun   <= 1'b0;
        end else begin
            if (core_textout_valid & (~rsp_valid | drain)) begin
                rsp_valid <= 1'b1;
                rsp_text  <= core_textout;
            end else if (drain) begin
                rsp_valid <= 1'b0;
            end
            if (core_textout_valid & rsp_valid & ~drain)
                overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_xoodyak_cmd_seq.sv
// Self-checking bench for xoodyak_cmd_seq: directed steps plus random traffic against a
// queue-based reference model. Honours XOOD_SEQ_STALL_EN when the design is built with it.
module tb_xoodyak_cmd_seq;

    localparam int DEPTH = 4;
    localparam int HOLD  = 4;
    localparam int W     = 352;

    localparam logic [191:0] TEXT_A = 192'hbb4416e8d6ce6ef456e2be6c08ce8eccaf42fd7c33b3de1e;
    localparam logic [191:0] TEXT_C = 192'h87a0c4e15b2d9f36a8e70c1d42f96b38d5a07e21c9b40e30;
    localparam logic [191:0] TEXT_D = 192'h0123456789abcdeffedcba98765432100f1e2d3c4b5a6978;
    localparam logic [351:0] DATA_1 = {128'h38393a3b3c3d3e3f3031323334353637, 224'h0};

    logic         eph1;
    logic         reset_n;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [4:0]   cmd_opmode;
    logic [351:0] cmd_data;
    logic [4:0]   core_opmode;
    logic [351:0] core_data;
    logic [191:0] core_textout;
    logic         core_textout_valid;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [191:0] rsp_text;
    logic         busy;
    logic         overrun;

    int checks_total;
    int checks_passed;
    int checks_failed;

    // Reference model: pending commands, the command on the core and its remaining window.
    logic [4:0]   mq_op   [$];
    logic [351:0] mq_data [$];
    bit           m_active;
    int           m_left;
    logic [4:0]   m_op;
    logic [351:0] m_data;
    bit           m_rv;
    logic [191:0] m_text;
    bit           m_over;
    bit           m_accepted;

    xoodyak_cmd_seq #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD)) dut (
        .eph1(eph1), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_opmode(cmd_opmode), .cmd_data(cmd_data),
        .core_opmode(core_opmode), .core_data(core_data),
        .core_textout(core_textout), .core_textout_valid(core_textout_valid),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_text(rsp_text),
        .busy(busy), .overrun(overrun)
    );

    initial begin
        eph1 = 1'b0;
        forever #5 eph1 = ~eph1;
    end

    function automatic logic [351:0] rand352();
        logic [351:0] v;
        for (int i = 0; i < 11; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [191:0] rand192();
        logic [191:0] v;
        for (int i = 0; i < 6; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic compare(input string tag, input logic [351:0] obs, input logic [351:0] exp);
        checks_total++;
        assert (obs === exp) checks_passed++;
        else begin
            checks_failed++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        mq_op.delete();
        mq_data.delete();
        m_active   = 1'b0;
        m_left     = 0;
        m_op       = '0;
        m_data     = '0;
        m_rv       = 1'b0;
        m_text     = '0;
        m_over     = 1'b0;
        m_accepted = 1'b0;
    endtask

    task automatic model_step();
        int qn;
        bit stall;
        bit drain;
        qn    = mq_op.size();
        stall = 1'b0;
        drain = m_rv && rsp_ready;
`ifdef XOOD_SEQ_STALL_EN
        stall = m_rv && !rsp_ready;
`endif
        m_accepted = cmd_valid && (qn < DEPTH);
        if (!m_active || m_left == 1) begin
            if (qn > 0 && !stall) begin
                m_op     = mq_op.pop_front();
                m_data   = mq_data.pop_front();
                m_active = 1'b1;
                m_left   = HOLD;
            end else begin
                m_active = 1'b0;
                m_op     = '0;
                m_data   = '0;
            end
        end else begin
            m_left--;
        end
        if (m_accepted) begin
            mq_op.push_back(cmd_opmode);
            mq_data.push_back(cmd_data);
        end
        if (core_textout_valid && m_rv && !drain) m_over = 1'b1;
        if (core_textout_valid && (!m_rv || drain)) begin
            m_text = core_textout;
            m_rv   = 1'b1;
        end else if (drain) begin
            m_rv = 1'b0;
        end
    endtask

    task automatic checkOutput();
        compare("cmd_ready",   W'(cmd_ready),   W'(mq_op.size() != DEPTH));
        compare("core_opmode", W'(core_opmode), W'(m_op));
        compare("core_data",   core_data,       m_data);
        compare("busy",        W'(busy),        W'(m_active || mq_op.size() != 0));
        compare("rsp_valid",   W'(rsp_valid),   W'(m_rv));
        compare("rsp_text",    W'(rsp_text),    W'(m_text));
        compare("overrun",     W'(overrun),     W'(m_over));
    endtask

    task automatic applyStimulus(input bit cv, input logic [4:0] op, input logic [351:0] data,
                                 input bit tv, input logic [191:0] text, input bit rr);
        cmd_valid          = cv;
        cmd_opmode         = op;
        cmd_data           = data;
        core_textout_valid = tv;
        core_textout       = text;
        rsp_ready          = rr;
        @(posedge eph1);
        model_step();
        #1;
        checkOutput();
    endtask

    task automatic idle_cycles(input int n, input bit rr);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 5'h0, '0, 1'b0, '0, rr);
    endtask

    task automatic push_cmd(input logic [4:0] op, input logic [351:0] data, input bit rr);
        bit done;
        done = 1'b0;
        for (int i = 0; i < 50 && !done; i++) begin
            applyStimulus(1'b1, op, data, 1'b0, '0, rr);
            done = m_accepted;
        end
        if (!done) compare("push_timeout", W'(1'b0), W'(1'b1));
    endtask

    initial begin
        checks_total  = 0;
        checks_passed = 0;
        checks_failed = 0;
        reset_n            = 1'b0;
        cmd_valid          = 1'b0;
        cmd_opmode         = '0;
        cmd_data           = '0;
        core_textout_valid = 1'b0;
        core_textout       = '0;
        rsp_ready          = 1'b0;
        model_reset();
        #12;
        compare("reset_cmd_ready", W'(cmd_ready), W'(1'b1));
        compare("reset_busy",      W'(busy),      W'(1'b0));
        checkOutput();
        reset_n = 1'b1;
        idle_cycles(2, 1'b0);

        $display("[TB] single command");
        push_cmd(5'h01, DATA_1, 1'b0);
        compare("single_latency", W'(core_opmode), W'(5'h00));
        for (int i = 0; i < HOLD; i++) begin
            idle_cycles(1, 1'b0);
            compare("single_hold_op",   W'(core_opmode), W'(5'h01));
            compare("single_hold_data", core_data, DATA_1);
        end
        idle_cycles(1, 1'b0);
        compare("single_after", W'(core_opmode), W'(5'h00));
        idle_cycles(2, 1'b0);

        $display("[TB] back-to-back and full FIFO");
        push_cmd(5'h01, rand352(), 1'b0);
        push_cmd(5'h02, rand352(), 1'b0);
        push_cmd(5'h03, rand352(), 1'b0);
        push_cmd(5'h03, rand352(), 1'b0);
        push_cmd(5'h04, rand352(), 1'b0);
        compare("full_cmd_ready", W'(cmd_ready), W'(1'b0));
        push_cmd(5'h05, rand352(), 1'b0);
        idle_cycles(30, 1'b0);
        compare("burst_done_busy", W'(busy), W'(1'b0));

        $display("[TB] response path");
        applyStimulus(1'b0, 5'h0, '0, 1'b1, TEXT_A, 1'b0);
        compare("rsp_capture_valid", W'(rsp_valid), W'(1'b1));
        compare("rsp_capture_text",  W'(rsp_text),  W'(TEXT_A));
        idle_cycles(1, 1'b0);
        compare("rsp_hold_valid", W'(rsp_valid), W'(1'b1));
        idle_cycles(1, 1'b1);
        compare("rsp_drain_valid", W'(rsp_valid), W'(1'b0));
        compare("rsp_drain_text",  W'(rsp_text),  W'(TEXT_A));

        $display("[TB] random traffic");
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 2) == 0, 5'($urandom), rand352(),
                          $urandom_range(0, 3) == 0, rand192(), $urandom_range(0, 1) == 1);
        end
        idle_cycles(40, 1'b1);
        compare("random_done_busy", W'(busy),      W'(1'b0));
        compare("random_done_rsp",  W'(rsp_valid), W'(1'b0));

        $display("[TB] overrun and simultaneous drain");
        applyStimulus(1'b0, 5'h0, '0, 1'b1, TEXT_A, 1'b0);
        applyStimulus(1'b0, 5'h0, '0, 1'b1, TEXT_C, 1'b0);
        compare("ovr_flag", W'(overrun),  W'(1'b1));
        compare("ovr_keep", W'(rsp_text), W'(TEXT_A));
        applyStimulus(1'b0, 5'h0, '0, 1'b1, TEXT_D, 1'b1);
        compare("simul_text",  W'(rsp_text),  W'(TEXT_D));
        compare("simul_valid", W'(rsp_valid), W'(1'b1));
        compare("simul_ovr",   W'(overrun),   W'(1'b1));

`ifdef XOOD_SEQ_STALL_EN
        $display("[TB] stall on full response buffer");
        push_cmd(5'h12, rand352(), 1'b0);
        push_cmd(5'h03, rand352(), 1'b0);
        idle_cycles(3, 1'b0);
        compare("stall_core_op", W'(core_opmode), W'(5'h00));
        compare("stall_busy",    W'(busy),        W'(1'b1));
        idle_cycles(1, 1'b1);
        compare("stall_release", W'(core_opmode), W'(5'h12));
        idle_cycles(12, 1'b0);
`endif

        $display("[TB] reset during issue");
        push_cmd(5'h01, rand352(), 1'b0);
        push_cmd(5'h02, rand352(), 1'b0);
        push_cmd(5'h03, rand352(), 1'b0);
        push_cmd(5'h04, rand352(), 1'b0);
        #3;
        reset_n = 1'b0;
        #1;
        compare("rst_core_op",   W'(core_opmode), W'(5'h00));
        compare("rst_core_data", core_data,       '0);
        compare("rst_rsp_valid", W'(rsp_valid),   W'(1'b0));
        compare("rst_rsp_text",  W'(rsp_text),    W'(192'h0));
        compare("rst_overrun",   W'(overrun),     W'(1'b0));
        compare("rst_busy",      W'(busy),        W'(1'b0));
        compare("rst_cmd_ready", W'(cmd_ready),   W'(1'b1));
        model_reset();
        @(posedge eph1);
        #1;
        reset_n = 1'b1;
        idle_cycles(3, 1'b0);
        compare("post_rst_cmd_ready", W'(cmd_ready), W'(1'b1));
        compare("post_rst_busy",      W'(busy),      W'(1'b0));

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
